// File: rtl/spi_ctrl_pkg.sv
// Shared field layout, FSM state type and helpers for the SPI control register.
package spi_ctrl_pkg;

    localparam int unsigned REG_W         = 32;
    localparam int unsigned SEND_BIT      = 0;
    localparam int unsigned CS_CTRL_BIT   = 1;
    localparam int unsigned ALL_ONES_BIT  = 2;
    localparam int unsigned ALL_ZEROS_BIT = 3;
    localparam int unsigned NTX_LSB       = 4;
    localparam int unsigned NRX_LSB       = 16;
    localparam int unsigned OVR_BIT       = 30;
    localparam int unsigned TMO_BIT       = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_e;

    function automatic logic [REG_W-1:0] field_mask(input int unsigned lsb, input int unsigned width);
        logic [REG_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < width; i++) begin
            m[lsb + i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/spi_ctrl_wr_arb.sv
// Priority selector over NUM_WR write ports; the highest-index asserted port wins outright.
module spi_ctrl_wr_arb
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]         wr_i,
    input  logic [NUM_WR*REG_W-1:0]   data_i,
    input  logic [NUM_WR*4-1:0]       be_i,
    output logic                      valid_o,
    output logic [REG_W-1:0]          data_o,
    output logic [3:0]                be_o
);

    // Ascending scan: a later (higher) port simply overwrites an earlier winner.
    always_comb begin
        valid_o = 1'b0;
        data_o  = '0;
        be_o    = '0;
        for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (wr_i[k]) begin
                valid_o = 1'b1;
                data_o  = data_i[REG_W*k +: REG_W];
                be_o    = be_i[4*k +: 4];
            end
        end
    end

endmodule

// File: rtl/spi_ctrl_reg.sv
// SPI control register with prioritised bus writes and the SEND/start handshake FSM.
// Optional START-state ack timeout enabled by defining SPI_CTRL_TIMEOUT_EN.
module spi_ctrl_reg
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_WR      = 2,
    parameter int unsigned NTX_W       = 9,
    parameter int unsigned NRX_W       = 9,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_WR-1:0]       wr_i,
    input  logic [NUM_WR*32-1:0]    data_i,
    input  logic [NUM_WR*4-1:0]     be_i,
    input  logic                    start_ack_i,
    input  logic                    done_i,
    input  logic [NRX_W-1:0]        rx_cnt_i,
    output logic [31:0]             ctrl_o,
    output logic                    start_o,
    output logic                    busy_o,
    output logic                    done_o
);

    if (NUM_WR < 1 || NTX_W < 1 || NTX_W > 12 || NRX_W < 1 || NRX_W > 14 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("spi_ctrl_reg: parameter out of range");
    end

    localparam logic [REG_W-1:0] CFG_MASK = field_mask(SEND_BIT, 4) | field_mask(NTX_LSB, NTX_W);

    logic              win_valid;
    logic [REG_W-1:0]  win_data;
    logic [3:0]        win_be;
    logic [REG_W-1:0]  wmask;
    logic [REG_W-1:0]  wbits;
    logic [REG_W-1:0]  ctrl_d;
    logic [REG_W-1:0]  ctrl_q;
    logic              done_evt;
    logic              tmo_evt;
    logic              launch;
    state_e            state_q;
    logic              start_q;
    logic              busy_q;
    logic              done_q;

`ifdef SPI_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] tmo_cnt_q;
`endif

    spi_ctrl_wr_arb #(
        .NUM_WR (NUM_WR)
    ) u_arb (
        .wr_i    (wr_i),
        .data_i  (data_i),
        .be_i    (be_i),
        .valid_o (win_valid),
        .data_o  (win_data),
        .be_o    (win_be)
    );

    always_comb begin
        wmask    = {{8{win_be[3]}}, {8{win_be[2]}}, {8{win_be[1]}}, {8{win_be[0]}}};
        wbits    = win_valid ? (win_data & wmask) : '0;
        done_evt = done_i && ((state_q == BUSY) || (state_q == START && start_ack_i));
`ifdef SPI_CTRL_TIMEOUT_EN
        tmo_evt  = (state_q == START) && !start_ack_i && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
        tmo_evt  = 1'b0;
`endif
        ctrl_d = ctrl_q;
        if (state_q == IDLE && win_valid) begin
            ctrl_d = (ctrl_q & ~CFG_MASK) | (((ctrl_q & ~wmask) | wbits) & CFG_MASK);
        end
        // Clear first, hardware set afterwards, so a simultaneous set wins over W1C.
        ctrl_d[OVR_BIT] = ctrl_d[OVR_BIT] & ~wbits[OVR_BIT];
        ctrl_d[TMO_BIT] = ctrl_d[TMO_BIT] & ~wbits[TMO_BIT];
        if (state_q != IDLE && wbits[SEND_BIT]) begin
            ctrl_d[OVR_BIT] = 1'b1;
        end
        if (done_evt) begin
            ctrl_d[SEND_BIT]             = 1'b0;
            ctrl_d[NRX_LSB +: NRX_W]     = rx_cnt_i;
        end
        if (tmo_evt) begin
            ctrl_d[SEND_BIT] = 1'b0;
            ctrl_d[TMO_BIT]  = 1'b1;
        end
        launch = (state_q == IDLE) && ctrl_d[SEND_BIT];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_CTRL_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            ctrl_q <= ctrl_d;
            done_q <= done_evt;
            unique case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef SPI_CTRL_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                START: begin
                    if (done_evt || tmo_evt) begin
                        state_q <= IDLE;
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (start_ack_i) begin
                        state_q <= BUSY;
                        start_q <= 1'b0;
                    end else begin
`ifdef SPI_CTRL_TIMEOUT_EN
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
`endif
                    end
                end
                BUSY: begin
                    if (done_evt) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_o  = ctrl_q;
    assign start_o = start_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
